// File: rtl/prism_trace_fifo_pkg.sv
// Shared constants for the PRISM FSM output trace FIFO: default sizes,
// entry field layout and status bit positions of the host read word.
package prism_trace_fifo_pkg;

    // Default block sizing
    localparam int DEF_DATA_W = 13;
    localparam int DEF_TS_W   = 16;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_LVL_W  = 4;

    // Stored entry layout: {cond, data[12:0], ts[15:0]}
    localparam int ENT_TS_LSB   = 0;
    localparam int ENT_DATA_LSB = 16;
    localparam int ENT_COND_BIT = 29;
    localparam int ENT_W        = 30;

    // Status bits placed above the entry in the host read word
    localparam int RD_OVF_BIT   = 30;
    localparam int RD_VALID_BIT = 31;

endpackage

// File: rtl/prism_trace_fifo_mem.sv
// Trace entry storage: DEPTH x ENT_W register file, one synchronous write
// port and one asynchronous read port. Contents are not reset; validity is
// tracked by the level counter in the parent.
module prism_trace_mem
    import prism_trace_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = ENT_W,
    parameter int PTR_W = $clog2(DEF_DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [W-1:0]     i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [W-1:0]     o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Write the incoming entry into the addressed slot
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prism_trace_fifo.sv
// PRISM trace FIFO: timestamps every change of the FSM output bus and
// condition bit, queues the entries for the host, and raises an interrupt
// on a fill threshold or on overflow.
module prism_trace_fifo
    import prism_trace_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TS_W   = DEF_TS_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int LVL_W  = DEF_LVL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [DATA_W-1:0] out_data,
    input  logic              cond_out,
    input  logic              rd_pop,
    input  logic [LVL_W-1:0]  thresh,
    output logic [31:0]       rd_data,
    output logic [LVL_W-1:0]  level,
    output logic              irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SMP_W = DATA_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    logic [TS_W-1:0]  r_ts;
    logic [SMP_W-1:0] r_prev;
    logic             r_armed;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_ovf;
    logic             r_irq;

    logic [SMP_W-1:0] w_sample;
    logic [ENT_W-1:0] w_entry;
    logic [ENT_W-1:0] w_head;
    logic             w_full;
    logic             w_push_req;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_we;
    logic [LVL_W-1:0] w_level_nxt;
    logic             w_ovf_nxt;
    logic             w_irq_nxt;

    assign w_sample = {cond_out, out_data};
    assign w_entry  = {cond_out, out_data, r_ts};

    // Push/pop arbitration, next-state level/overflow and interrupt
    always_comb begin
        w_full      = 1'b0;
        w_push_req  = 1'b0;
        w_pop_ok    = 1'b0;
        w_push_ok   = 1'b0;
        w_we        = 1'b0;
        w_level_nxt = r_level;
        w_ovf_nxt   = r_ovf;
        w_irq_nxt   = 1'b0;

        w_full     = (r_level == LVL_FULL);
        w_push_req = enable && (r_armed || (w_sample != r_prev));
        w_pop_ok   = rd_pop && (r_level != LVL_ZERO);
        // A full FIFO still accepts a push when the head leaves the same cycle
        w_push_ok  = w_push_req && (!w_full || w_pop_ok);

        if (clear) begin
            w_we        = 1'b0;
            w_level_nxt = LVL_ZERO;
            w_ovf_nxt   = 1'b0;
        end else begin
            w_we = w_push_ok;
            case ({w_push_ok, w_pop_ok})
                2'b10:   w_level_nxt = r_level + LVL_ONE;
                2'b01:   w_level_nxt = r_level - LVL_ONE;
                default: w_level_nxt = r_level;
            endcase
            w_ovf_nxt = r_ovf || (w_push_req && w_full && !w_pop_ok);
        end

        w_irq_nxt = ((thresh != LVL_ZERO) && (w_level_nxt >= thresh)) || w_ovf_nxt;
    end

    // Timestamp, change-detect history and re-arm flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts    <= {TS_W{1'b0}};
            r_prev  <= {SMP_W{1'b0}};
            r_armed <= 1'b1;
        end else begin
            if (clear) begin
                r_ts <= {TS_W{1'b0}};
            end else if (enable) begin
                r_ts <= r_ts + TS_W'(1);
            end
            if (enable) begin
                r_prev <= w_sample;
            end
            // Re-arm whenever capture is idle or flushed so the next enabled
            // cycle always produces an entry
            r_armed <= clear || !enable;
        end
    end

    // FIFO pointers, fill level, sticky overflow and registered interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= LVL_ZERO;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (clear) begin
                r_wr_ptr <= {PTR_W{1'b0}};
                r_rd_ptr <= {PTR_W{1'b0}};
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
            r_level <= w_level_nxt;
            r_ovf   <= w_ovf_nxt;
            r_irq   <= w_irq_nxt;
        end
    end

    prism_trace_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    // Host read word: head entry with status, entry field masked when empty
    always_comb begin
        rd_data = 32'h0000_0000;
        if (r_level != LVL_ZERO) begin
            rd_data = {1'b1, r_ovf, w_head};
        end else begin
            rd_data = {1'b0, r_ovf, {ENT_W{1'b0}}};
        end
    end

    assign level = r_level;
    assign irq   = r_irq;

endmodule

// File: tb/tb_prism_trace_fifo.sv
// Self-checking bench for prism_trace_fifo: a reference queue holds the
// entries the FIFO should contain; each scenario task compares the DUT
// outputs against it and against hand-derived constants.
module tb_prism_trace_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [12:0] out_data;
    logic        cond_out;
    logic        rd_pop;
    logic [3:0]  thresh;
    logic [31:0] rd_data;
    logic [3:0]  level;
    logic        irq;

    always #5 clk = ~clk;

    prism_trace_fifo dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .clear    (clear),
        .out_data (out_data),
        .cond_out (cond_out),
        .rd_pop   (rd_pop),
        .thresh   (thresh),
        .rd_data  (rd_data),
        .level    (level),
        .irq      (irq)
    );

    int checks   = 0;
    int failures = 0;

    logic [29:0] exp_q[$];
    logic [15:0] m_ts;
    logic [13:0] m_prev;
    logic        m_armed;
    logic        m_ovf;
    logic        cur_c;
    logic [12:0] cur_d;

    function automatic logic [31:0] exp_rd();
        if (exp_q.size() > 0) return {1'b1, m_ovf, exp_q[0]};
        else return {1'b0, m_ovf, 30'd0};
    endfunction

    function automatic logic exp_irq();
        return ((thresh != 4'd0) && (4'(exp_q.size()) >= thresh)) || m_ovf;
    endfunction

    // Drive one clock cycle of stimulus and advance the reference model
    task automatic cycle(input logic en, input logic c, input logic [12:0] d,
                         input logic pop, input logic clr);
        logic [13:0] smp;
        logic        req;
        enable = en; cond_out = c; out_data = d; rd_pop = pop; clear = clr;
        smp = {c, d};
        if (clr) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            req = en && (m_armed || (smp != m_prev));
            if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (req) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({c, d, m_ts});
                else m_ovf = 1'b1;
            end
        end
        if (clr) m_ts = 16'h0000;
        else if (en) m_ts = m_ts + 16'h0001;
        m_armed = clr || !en;
        if (en) m_prev = smp;
        @(posedge clk);
        #1;
        rd_pop = 1'b0;
        clear  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; out_data = 13'h0000;
        cond_out = 1'b0; rd_pop = 1'b0; thresh = 4'd0;
        m_ts = 16'h0000; m_prev = 14'h0000; m_armed = 1'b1; m_ovf = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++;
        if (rd_data !== 32'h0000_0000) begin failures++; $display("FAIL reset_rd_data got=%h exp=00000000", rd_data); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_entries();
        logic [31:0] consts [3];
        consts[0] = 32'h8000_0000;
        consts[1] = 32'h8005_000A;
        consts[2] = 32'h9FFF_000B;
        cycle(1'b1, 1'b0, 13'h0000, 1'b0, 1'b0);
        checks++;
        if (level !== 4'd1) begin failures++; $display("FAIL first_level got=%0d exp=1", level); end
        checks++;
        if (rd_data !== 32'h8000_0000) begin failures++; $display("FAIL first_rd_data got=%h exp=80000000", rd_data); end
        repeat (9) cycle(1'b1, 1'b0, 13'h0000, 1'b0, 1'b0);
        checks++;
        if (level !== 4'd1) begin failures++; $display("FAIL held_level got=%0d exp=1", level); end
        cycle(1'b1, 1'b0, 13'h0005, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 13'h1FFF, 1'b0, 1'b0);
        checks++;
        if (level !== 4'd3) begin failures++; $display("FAIL three_level got=%0d exp=3", level); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_data !== consts[i]) begin failures++; $display("FAIL pop_const[%0d] got=%h exp=%h", i, rd_data, consts[i]); end
            checks++;
            if (rd_data !== exp_rd()) begin failures++; $display("FAIL pop_sb[%0d] got=%h exp=%h", i, rd_data, exp_rd()); end
            cycle(1'b1, 1'b0, 13'h1FFF, 1'b1, 1'b0);
        end
        checks++;
        if (level !== 4'd0) begin failures++; $display("FAIL drained_level got=%0d exp=0", level); end
        checks++;
        if (rd_data[31] !== 1'b0) begin failures++; $display("FAIL drained_valid got=%b exp=0", rd_data[31]); end
        cycle(1'b1, 1'b0, 13'h1FFF, 1'b1, 1'b0);
        checks++;
        if (level !== 4'd0) begin failures++; $display("FAIL empty_pop_level got=%0d exp=0", level); end
        cur_c = 1'b0; cur_d = 13'h1FFF;
    endtask

    task automatic test_overflow();
        cycle(1'b1, cur_c, cur_d, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cur_c = ~cur_c;
            cycle(1'b1, cur_c, cur_d, 1'b0, 1'b0);
        end
        checks++;
        if (level !== 4'd8) begin failures++; $display("FAIL ovf_level got=%0d exp=8", level); end
        checks++;
        if (rd_data[30] !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", rd_data[30]); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL ovf_irq got=%b exp=1", irq); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_data !== exp_rd()) begin failures++; $display("FAIL ovf_entry_sb[%0d] got=%h exp=%h", i, rd_data, exp_rd()); end
            checks++;
            if (rd_data[15:0] !== 16'(i)) begin failures++; $display("FAIL ovf_entry_ts[%0d] got=%h exp=%h", i, rd_data[15:0], 16'(i)); end
            cycle(1'b0, cur_c, cur_d, 1'b1, 1'b0);
        end
        checks++;
        if (rd_data !== 32'h4000_0000) begin failures++; $display("FAIL ovf_sticky got=%h exp=40000000", rd_data); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL ovf_sticky_irq got=%b exp=1", irq); end
        cycle(1'b0, cur_c, cur_d, 1'b0, 1'b1);
        checks++;
        if (rd_data !== 32'h0000_0000 || level !== 4'd0) begin
            failures++; $display("FAIL clear_state rd_data=%h level=%0d exp=00000000/0", rd_data, level);
        end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL clear_irq got=%b exp=0", irq); end
        cycle(1'b1, cur_c, cur_d, 1'b0, 1'b0);
        checks++;
        if (rd_data !== {2'b10, cur_c, cur_d, 16'h0000}) begin
            failures++; $display("FAIL clear_ts_zero got=%h exp=%h", rd_data, {2'b10, cur_c, cur_d, 16'h0000});
        end
    endtask

    task automatic test_full_push_pop();
        logic [29:0] second;
        for (int i = 0; i < 7; i++) begin
            cur_c = ~cur_c;
            cycle(1'b1, cur_c, cur_d, 1'b0, 1'b0);
        end
        checks++;
        if (level !== 4'd8 || rd_data[30] !== 1'b0) begin
            failures++; $display("FAIL full_fill level=%0d ovf=%b exp=8/0", level, rd_data[30]);
        end
        second = exp_q[1];
        cur_c = ~cur_c;
        cycle(1'b1, cur_c, cur_d, 1'b1, 1'b0);
        checks++;
        if (level !== 4'd8) begin failures++; $display("FAIL pushpop_level got=%0d exp=8", level); end
        checks++;
        if (rd_data[30] !== 1'b0 || irq !== 1'b0) begin
            failures++; $display("FAIL pushpop_ovf ovf=%b irq=%b exp=0/0", rd_data[30], irq);
        end
        checks++;
        if (rd_data[29:0] !== second) begin failures++; $display("FAIL pushpop_head got=%h exp=%h", rd_data[29:0], second); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_data !== exp_rd()) begin failures++; $display("FAIL pushpop_drain[%0d] got=%h exp=%h", i, rd_data, exp_rd()); end
            if (i == 7) begin
                checks++;
                if (rd_data[15:0] !== 16'h0008) begin failures++; $display("FAIL pushpop_tail_ts got=%h exp=0008", rd_data[15:0]); end
            end
            cycle(1'b0, cur_c, cur_d, 1'b1, 1'b0);
        end
        checks++;
        if (level !== 4'd0) begin failures++; $display("FAIL pushpop_empty got=%0d exp=0", level); end
    endtask

    task automatic test_threshold();
        thresh = 4'd3;
        cycle(1'b0, cur_c, cur_d, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cur_c = ~cur_c;
            cycle(1'b1, cur_c, cur_d, 1'b0, 1'b0);
            checks++;
            if (irq !== (i == 2)) begin failures++; $display("FAIL thresh_rise[%0d] got=%b exp=%b", i, irq, (i == 2)); end
        end
        cycle(1'b1, cur_c, cur_d, 1'b1, 1'b0);
        checks++;
        if (level !== 4'd2 || irq !== 1'b0) begin
            failures++; $display("FAIL thresh_fall level=%0d irq=%b exp=2/0", level, irq);
        end
        thresh = 4'd0;
        cycle(1'b1, cur_c, cur_d, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cur_c = ~cur_c;
            cycle(1'b1, cur_c, cur_d, 1'b0, 1'b0);
            checks++;
            if (irq !== exp_irq() || level !== 4'(exp_q.size())) begin
                failures++; $display("FAIL thresh0_step[%0d] irq=%b level=%0d exp=%b/%0d", i, irq, level, exp_irq(), exp_q.size());
            end
        end
        checks++;
        if (level !== 4'd8 || irq !== 1'b0 || rd_data[30] !== 1'b0) begin
            failures++; $display("FAIL thresh0_full level=%0d irq=%b ovf=%b exp=8/0/0", level, irq, rd_data[30]);
        end
    endtask

    task automatic test_ts_wrap();
        cycle(1'b1, cur_c, cur_d, 1'b0, 1'b1);
        while (m_ts != 16'hFFFF) begin
            cycle(1'b1, cur_c, cur_d, (exp_q.size() > 0), 1'b0);
        end
        checks++;
        if (level !== 4'd0) begin failures++; $display("FAIL wrap_pre_level got=%0d exp=0", level); end
        cur_d = 13'h00AA;
        cycle(1'b1, cur_c, cur_d, 1'b0, 1'b0);
        cur_d = 13'h0155;
        cycle(1'b1, cur_c, cur_d, 1'b0, 1'b0);
        checks++;
        if (level !== 4'd2) begin failures++; $display("FAIL wrap_level got=%0d exp=2", level); end
        checks++;
        if (rd_data !== {2'b10, cur_c, 13'h00AA, 16'hFFFF}) begin
            failures++; $display("FAIL wrap_ts_ffff got=%h exp=%h", rd_data, {2'b10, cur_c, 13'h00AA, 16'hFFFF});
        end
        cycle(1'b1, cur_c, cur_d, 1'b1, 1'b0);
        checks++;
        if (rd_data !== {2'b10, cur_c, 13'h0155, 16'h0000}) begin
            failures++; $display("FAIL wrap_ts_0000 got=%h exp=%h", rd_data, {2'b10, cur_c, 13'h0155, 16'h0000});
        end
        cycle(1'b1, cur_c, cur_d, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, cur_c, cur_d, 1'b0, 1'b0);
        checks++;
        if (level !== 4'd0) begin failures++; $display("FAIL rearm_idle_level got=%0d exp=0", level); end
        cycle(1'b1, cur_c, cur_d, 1'b0, 1'b0);
        checks++;
        if (rd_data !== {2'b10, cur_c, 13'h0155, 16'h0003}) begin
            failures++; $display("FAIL rearm_entry got=%h exp=%h", rd_data, {2'b10, cur_c, 13'h0155, 16'h0003});
        end
        checks++;
        if (rd_data !== exp_rd()) begin failures++; $display("FAIL rearm_sb got=%h exp=%h", rd_data, exp_rd()); end
    endtask

    initial begin
        cur_c = 1'b0;
        cur_d = 13'h0000;
        test_reset();
        test_first_entries();
        test_overflow();
        test_full_push_pop();
        test_threshold();
        test_ts_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prism_trace_fifo.md
Name: prism_trace_fifo

Overview:
- Downstream capture stage for the PRISM FSM outputs.
- Watches the 13-bit FSM output bus plus the condition output.
- Records every change as a timestamped entry in a small FIFO, which the TinyQV host drains over the peripheral register path.
- Raises an interrupt on a fill threshold or on overflow, so software can trace FSM output activity without polling every cycle.

Parameters:
- DATA_W, 13, width of FSM output bus captured.
- TS_W, 16, timestamp counter width.
- DEPTH, 8, FIFO entries (power of two, >=2).
- LVL_W, 4, width of level/threshold fields (must hold DEPTH).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- enable  input  1  capture enable (driven from the FSM-enable control bit).
- clear  input  1  synchronous flush pulse: empties FIFO, zeroes timestamp, clears overflow.
- out_data  input  DATA_W  FSM output bus being traced.
- cond_out  input  1  FSM condition output, traced alongside out_data.
- rd_pop  input  1  one-cycle pulse: discard head entry (host read-and-advance).
- thresh  input  LVL_W  interrupt threshold; 0 disables the level interrupt.
- rd_data  output  32  {not_empty, overflow, cond, data[12:0], ts[15:0]} of head entry.
- level  output  LVL_W  number of valid entries, 0..DEPTH.
- irq  output  1  (thresh!=0 && level>=thresh) || overflow.

Behaviour:
- Reset values: FIFO empty, level=0, overflow=0, ts=0, armed=1, prev sample=0, rd_data=0, irq=0.
- Timestamp:
  - ts increments by 1 every cycle while enable=1; holds while enable=0.
  - Wraps from 2^TS_W-1 to 0 silently.
  - clear forces ts=0.
- Change detection:
  - Each cycle with enable=1, compare {cond_out,out_data} against registered prev.
  - Push request when they differ, or when armed=1.
  - prev updates every enabled cycle.
  - armed is set by reset, by clear, and on each cycle with enable=0. It is cleared after the first enabled cycle, so the first sample after enable rises is always recorded.
- Entry contents: {cond_out, out_data, ts}, sampled in the same cycle N the change is seen. ts is the pre-increment value of cycle N.
- Entry becomes visible at the head (level updated) at cycle N+1.
- Read side:
  - First-word fall-through; rd_data is combinational from the head entry plus status bits.
  - When empty: rd_data[31]=0, rd_data[30]=overflow, rd_data[29:0]=0.
  - rd_pop when empty is ignored.
- Full:
  - A push request while full and with no pop that cycle is dropped; sticky overflow is set.
  - Existing entries are never overwritten.
- Simultaneous push and pop:
  - Both succeed and level is unchanged, including when full, in which case no overflow is set.
  - When empty, the pop is ignored and the push succeeds.
- Priority: clear > (push/pop). A clear coincident with a push discards that sample and re-arms, so the next enabled cycle records.
- overflow is cleared only by clear or reset; pops do not clear it.
- Pointers: wr/rd pointers are log2(DEPTH) bits wrapping modulo DEPTH; level is a separate counter (no pointer-MSB trick).
- irq is registered from next-state level/overflow: it asserts the cycle level reaches thresh and deasserts the cycle after a pop or clear drops it below.
- Reset mid-operation: asynchronous clear of all state; entries contents need not be zeroed, but must be unreadable (not_empty=0).

Decomposition:
- Shared package:
  - entry field widths/offsets (ENT_TS_LSB=0, ENT_DATA_LSB=16, ENT_COND_BIT=29).
  - status bit positions (RD_OVF_BIT=30, RD_VALID_BIT=31).
  - default DEPTH/TS_W constants.
- One sub-module: prism_trace_mem, a DEPTH x 30 register-file storage with one write port and one asynchronous read port.
- Pointer, level, change-detect and irq logic stay in the top.

Test Plan:
- Reset, then enable=1 with out_data=0x000 held → exactly one entry {cond=0,data=0,ts=0}; level=1; rd_data=0x8000_0000.
- Change out_data to 0x005 at ts=10, then 0x1FFF at ts=11 → two further entries with ts 10 and 11. Pop three times gives entries ts 0,10,11, then level=0 and rd_data[31]=0.
- Toggle cond_out every cycle for 10 cycles, no pops, DEPTH=8 → level=8, overflow=1, irq=1. First 8 samples retained, in order; clear → level=0, overflow=0, irq=0, ts=0.
- FIFO full; push and pop in the same cycle → level stays 8, overflow stays 0, new entry at tail, old head gone.
- thresh=3; generate 3 changes → irq rises the cycle level becomes 3; one pop → irq low next cycle. thresh=0 with level=8, no overflow → irq=0.
- Run ts across 0xFFFF with a change at 0xFFFF and at the next cycle → entries ts 0xFFFF then 0x0000. Deassert then reassert enable with data unchanged → re-armed entry recorded, and ts resumes from its held value.
